// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: STAGES-deep ripple add/subtract, WIDTH/STAGES bits resolved per stage,
// with a whole-pipeline stall driven by the output handshake.
module pipelined_add_sub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             ovf,
    output logic             zero
);
    localparam int SW = WIDTH / STAGES;
    localparam int L  = STAGES - 1;

    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic [STAGES-1:0] v_q, v_d, c_q, c_d;
    logic ovf_q, ovf_d, zero_q, zero_d;

    logic [WIDTH-1:0] a_in [STAGES];
    logic [WIDTH-1:0] b_in [STAGES];
    logic [WIDTH-1:0] s_in [STAGES];
    logic c_in [STAGES];
    logic v_in [STAGES];
    logic adv;
    logic [SW:0] sl;
    logic [WIDTH-1:0] nxt;

    // Stage 0 takes the operands with B and the carry already inverted for subtract.
    assign a_in[0] = A;
    assign b_in[0] = sub ? ~B : B;
    assign s_in[0] = '0;
    assign c_in[0] = sub ? ~Cin : Cin;
    assign v_in[0] = in_valid;

    for (genvar i = 1; i < STAGES; i++) begin : g_link
        assign a_in[i] = a_q[i-1];
        assign b_in[i] = b_q[i-1];
        assign s_in[i] = s_q[i-1];
        assign c_in[i] = c_q[i-1];
        assign v_in[i] = v_q[i-1];
    end

    assign adv       = !(v_q[L] && !out_ready);
    assign in_ready  = adv;
    assign out_valid = v_q[L];
    assign Sum       = s_q[L];
    assign Cout      = c_q[L];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    always_comb begin
        v_d    = v_q;
        c_d    = c_q;
        a_d    = a_q;
        b_d    = b_q;
        s_d    = s_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;
        sl     = '0;
        nxt    = '0;
        for (int s = 0; s < STAGES; s++) begin
            sl  = {1'b0, a_in[s][s*SW +: SW]} + {1'b0, b_in[s][s*SW +: SW]} + (SW+1)'(c_in[s]);
            nxt = s_in[s];
            nxt[s*SW +: SW] = sl[SW-1:0];
            if (adv) begin
                a_d[s] = a_in[s];
                b_d[s] = b_in[s];
                s_d[s] = nxt;
                c_d[s] = sl[SW];
                v_d[s] = v_in[s];
            end
        end
        // nxt now holds the complete sum entering the last stage.
        if (adv) begin
            ovf_d  = (a_in[L][WIDTH-1] == b_in[L][WIDTH-1]) && (nxt[WIDTH-1] != a_in[L][WIDTH-1]);
            zero_d = (nxt == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                a_q[s] <= '0;
                b_q[s] <= '0;
                s_q[s] <= '0;
            end
        end else begin
            v_q    <= v_d;
            c_q    <= c_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            for (int s = 0; s < STAGES; s++) begin
                a_q[s] <= a_d[s];
                b_q[s] <= b_d[s];
                s_q[s] <= s_d[s];
            end
        end
    end
endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb_pipelined_add_sub: directed tests for the 8-bit, 2-stage add/subtract pipeline.
module tb_pipelined_add_sub;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, in_ready;
    logic [7:0] A = '0, B = '0;
    logic Cin = 1'b0, sub = 1'b0;
    logic out_valid, out_ready = 1'b1;
    logic [7:0] Sum;
    logic Cout, ovf, zero;
    int passed = 0;
    int total = 0;

    pipelined_add_sub #(.WIDTH(8), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Cout(Cout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        total++;
        if ({out_valid, Sum, Cout, ovf, zero} !== 12'h000) $display("FAIL reset_outputs: got %h want 000", {out_valid, Sum, Cout, ovf, zero});
        else passed++;
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else passed++;
        rst = 1'b0;
    endtask

    // One operation straight through: checks latency and the flag set.
    task automatic single_op(input string name, input logic [7:0] a, input logic [7:0] b,
                             input logic c, input logic s, input logic [11:0] exp);
        in_valid = 1'b1; A = a; B = b; Cin = c; sub = s;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL %s_accept: in_ready got %b want 1", name, in_ready);
        else passed++;
        step();
        in_valid = 1'b0; A = 8'hAA; B = 8'h55; Cin = ~c; sub = ~s;
        total++;
        if (out_valid !== 1'b0) $display("FAIL %s_early: out_valid got %b want 0", name, out_valid);
        else passed++;
        step();
        total++;
        if ({out_valid, Sum, Cout, ovf, zero} !== exp) $display("FAIL %s: {v,Sum,Cout,ovf,zero} got %h want %h", name, {out_valid, Sum, Cout, ovf, zero}, exp);
        else passed++;
        step();
    endtask

    task automatic test_add();
        single_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, {1'b1, 8'h00, 1'b1, 1'b0, 1'b1});
        single_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, {1'b1, 8'h80, 1'b0, 1'b1, 1'b0});
        single_op("add_cin",   8'h12, 8'h34, 1'b1, 1'b0, {1'b1, 8'h47, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic test_sub();
        single_op("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, {1'b1, 8'hFE, 1'b0, 1'b0, 1'b0});
        single_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 8'h7F, 1'b1, 1'b1, 1'b0});
        single_op("sub_zero",  8'h09, 8'h08, 1'b1, 1'b1, {1'b1, 8'h00, 1'b1, 1'b0, 1'b1});
    endtask

    task automatic test_back_to_back();
        int sent = 0, got = 0, stall_left = 0;
        logic first_seen = 1'b0;
        logic [7:0] exp [4] = '{8'd2, 8'd4, 8'd6, 8'd8};
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            if (out_valid && !first_seen) begin
                first_seen = 1'b1;
                stall_left = 3;
            end
            out_ready = !(out_valid && stall_left > 0);
            in_valid = sent < 4;
            A = 8'(sent + 1); B = 8'(sent + 1); Cin = 1'b0; sub = 1'b0;
            #1;
            if (out_valid && !out_ready) begin
                stall_left--;
                total++;
                if (in_ready !== 1'b0) $display("FAIL b2b_stall_ready: in_ready got %b want 0", in_ready);
                else passed++;
                total++;
                if (Sum !== exp[got]) $display("FAIL b2b_stall_hold: Sum got %h want %h", Sum, exp[got]);
                else passed++;
            end
            if (out_valid && out_ready) begin
                total++;
                if (Sum !== exp[got]) $display("FAIL b2b_result%0d: Sum got %h want %h", got, Sum, exp[got]);
                else passed++;
                got++;
            end
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        total++;
        if (got !== 4) $display("FAIL b2b_count: results got %0d want 4", got);
        else passed++;
        total++;
        if (out_valid !== 1'b0) $display("FAIL b2b_drained: out_valid got %b want 0", out_valid);
        else passed++;
    endtask

    task automatic test_mode_alt();
        logic [9:0] exp_add = {1'b1, 8'h12, 1'b0};
        logic [9:0] exp_sub = {1'b1, 8'h0E, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = i < 4;
            A = 8'h10; B = 8'h01; Cin = 1'b1; sub = i[0];
            #1;
            if (i >= 2) begin
                total++;
                if ({out_valid, Sum, Cout} !== (i[0] ? exp_sub : exp_add))
                    $display("FAIL mode_alt%0d: {v,Sum,Cout} got %h want %h", i - 2, {out_valid, Sum, Cout}, i[0] ? exp_sub : exp_add);
                else passed++;
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        in_valid = 1'b1; A = 8'h01; B = 8'h01; Cin = 1'b0; sub = 1'b0;
        step();
        A = 8'h02; B = 8'h02;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if ({out_valid, Sum, Cout, ovf, zero} !== 12'h000) $display("FAIL midreset_clear: got %h want 000", {out_valid, Sum, Cout, ovf, zero});
        else passed++;
        total++;
        if (in_ready !== 1'b1) $display("FAIL midreset_ready: in_ready got %b want 1", in_ready);
        else passed++;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_valid !== 1'b0) $display("FAIL midreset_quiet%0d: out_valid got %b want 0", i, out_valid);
            else passed++;
            step();
        end
        single_op("post_reset", 8'h30, 8'h0C, 1'b0, 1'b0, {1'b1, 8'h3C, 1'b0, 1'b0, 1'b0});
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_mode_alt();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
